alu_share_ctrl: RTL
===================

// Module: alu_share_ctrl
// PURPOSE
//  Round-robin controller that shares one ALUWithControl-style ALU between NREQ requesters.
//  - ALU interface: 4-bit ALUctl, 32-bit A/B in; 32-bit ALUOut and Zero back.
//  - Captures one request, drives the ALU, registers the result, returns it by valid/ready.
//  - Sits between the decode/issue logic and the single shared combinational ALU.
// PARAMETERS
//  NREQ   2   number of requesters (2..8)
//  W      32  operand/result width (must match ALU)
// PORTS
//  clk        in   1        rising-edge clock, the only clock
//  rst        in   1        asynchronous, active-high reset
//  req_valid  in   NREQ     requester i presents an operation
//  req_ready  out  NREQ     one-hot accept strobe (handshake when valid&ready)
//  req_op     in   4*NREQ   ALUctl code per requester, slice i = [4i+3:4i]
//  req_a      in   W*NREQ   operand A per requester
//  req_b      in   W*NREQ   operand B per requester
//  rsp_valid  out  NREQ     one-hot: result ready for requester i
//  rsp_ready  in   NREQ     requester i takes the result
//  rsp_data   out  W        registered ALU result
//  rsp_zero   out  1        registered Zero flag
//  rsp_err    out  1        1 = op code unsupported; rsp_data = 0, rsp_zero = 1
//  alu_ctl    out  4        to ALU ALUctl
//  alu_a      out  W        to ALU A
//  alu_b      out  W        to ALU B
//  alu_out    in   W        from ALU ALUOut
//  alu_zero   in   1        from ALU Zero
// BEHAVIOUR
//  Reset: every output 0, state IDLE, rr_ptr = 0, capture registers 0. Reset mid-op drops the in-flight op without responding.
//  FSM:
//   IDLE -> EXEC: when any req_valid is set.
//     - Arbiter picks the first valid index at or after rr_ptr (wrapping).
//     - req_ready[g] is asserted combinationally in the same cycle.
//     - op, a and b are captured into op_q, a_q, b_q; g is captured into gnt_q.
//   EXEC -> RESP: exactly one cycle.
//     - alu_ctl = op_q, alu_a = a_q, alu_b = b_q.
//     - alu_out/alu_zero are registered into rsp_data/rsp_zero at the end of EXEC.
//   RESP -> IDLE: when rsp_valid[gnt_q] & rsp_ready[gnt_q].
//     - rsp_valid[gnt_q] is held and rsp_data is stable until then.
//  req_ready is 0 in EXEC and RESP. No new accept in the cycle RESP completes; next accept is the following cycle.
//  Latency: accept edge = cycle 0; rsp_valid high from cycle 2. Best-case throughput: 1 op per 3 cycles.
//  rr_ptr update: on accept, rr_ptr <= (g+1) mod NREQ. Wrap from NREQ-1 to 0.
//  No requester wins twice while another requester is continuously valid.
//  Supported op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
//   - SLT returns the ALU's own constant; the controller does not reinterpret it.
//   - Any other code: rsp_err = 1, rsp_data = 0, rsp_zero = 1. alu_ctl is still driven with 0010 so the ALU output is defined.
//  alu_ctl/alu_a/alu_b hold op_q/a_q/b_q in every state. A change on req_* after accept has no effect.
//  Simultaneous valids: only the grant winner's req_ready rises; the others wait with their inputs held.
//  rsp_ready to a non-granted index is ignored. A requester dropping req_valid while not granted is legal.
// STRUCTURE
//  Shared package alu_pkg:
//   - localparams ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111
//   - state encodings S_IDLE, S_EXEC, S_RESP (2 bits)
//   - function op_supported(op)
//  Sub-module rr_arbiter:
//   - parameter N; inputs req[N], ptr, en
//   - outputs one-hot gnt[N] and index gnt_idx; purely combinational
//  Top holds the FSM, capture registers, response registers and the ALU drive.
// TESTING
//  1. Single ADD: req0 a=5, b=7, op=0010, rsp_ready=1.
//     -> req_ready[0] in cycle 0; rsp_valid[0] in cycle 2; data=12, zero=0, err=0.
//  2. SUB to zero: req1 a=b=32'h0000_00FF, op=0110.
//     -> rsp_valid[1], data=0, zero=1.
//  3. Contention: req0 and req1 both held valid for 4 ops.
//     -> grants 0,1,0,1. Each requester's req_ready fires only once per op.
//  4. Backpressure: rsp_ready held 0 for 5 cycles after rsp_valid.
//     -> rsp_valid/data held stable; req_ready stays 0; accept occurs the cycle after the handshake.
//  5. Bad op 4'b1010: -> rsp_err=1, data=0, zero=1. A following AND (F0 & 3C) -> 30, err=0.
//  6. Reset in EXEC: assert rst one cycle.
//     -> all outputs 0 immediately; no rsp_valid; the next request is granted from index 0.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the ALU sharing controller.
//                ALUctl encodings, controller state encoding and the
//                op-code support check.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALUctl encodings understood by the shared ALU
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // Controller states
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

    // 1 when the ALU defines a result for this code
    function automatic logic op_supported(input logic [3:0] op);
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: op_supported = 1'b1;
            default:                                    op_supported = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Grants the first
//                requesting index at or after ptr, wrapping to 0.
//  Ports       : req     in  N   request vector
//                ptr     in  IW  highest-priority index
//                en      in  1   grant enable
//                gnt     out N   one-hot grant
//                gnt_idx out IW  binary index of the grant
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic w_found;

    // Two ordered scans: first the indices at or above ptr, then the
    // wrapped-around indices below it. The first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (en && !w_found && req[i] && (i >= int'(ptr))) begin
                w_found = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (en && !w_found && req[i]) begin
                w_found = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = IW'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_ctrl
//  Description : Round-robin controller sharing one combinational ALU
//                between NREQ requesters. Captures one request, drives
//                the ALU for one cycle, registers the result and returns
//                it with a valid/ready handshake.
//  Ports       : clk, rst               clock, async active-high reset
//                req_valid/req_ready    per-requester request handshake
//                req_op/req_a/req_b     packed per-requester operation
//                rsp_valid/rsp_ready    per-requester response handshake
//                rsp_data/rsp_zero      registered ALU result and Zero
//                rsp_err                unsupported op code
//                alu_ctl/alu_a/alu_b    drive to the shared ALU
//                alu_out/alu_zero       result from the shared ALU
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_op,
    input  logic [W*NREQ-1:0] req_a,
    input  logic [W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic [3:0]        alu_ctl,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    input  logic [W-1:0]      alu_out,
    input  logic              alu_zero
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_gnt;
    logic [3:0]      r_op;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_data;
    logic            r_zero;
    logic            r_err;

    logic            w_arb_en;
    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_gnt_idx;
    logic            w_accept;
    logic [3:0]      w_sel_op;
    logic [W-1:0]    w_sel_a;
    logic [W-1:0]    w_sel_b;

    // Grants are only offered in IDLE; rst also masks them so every
    // output is low while reset is held.
    assign w_arb_en = (r_state == S_IDLE) && !rst;
    assign w_accept = |w_gnt;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (r_ptr),
        .en      (w_arb_en),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    // Operand select from the granted requester
    always_comb begin
        w_sel_op = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_op = req_op[i*4 +: 4];
                w_sel_a  = req_a[i*W +: W];
                w_sel_b  = req_b[i*W +: W];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        rsp_valid   = '0;
        case (r_state)
            S_IDLE: begin
                req_ready = w_gnt;
                if (w_accept) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid[r_gnt] = 1'b1;
                // rsp_ready from any other index is deliberately ignored
                if (rsp_ready[r_gnt]) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture on accept; the captured values stay on the ALU in all
    // states so later changes on req_* cannot disturb an in-flight op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
            r_gnt <= '0;
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
        end else if (w_accept) begin
            r_gnt <= w_gnt_idx;
            r_op  <= w_sel_op;
            r_a   <= w_sel_a;
            r_b   <= w_sel_b;
            if (w_gnt_idx == IW'(NREQ - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_gnt_idx + IW'(1);
            end
        end
    end

    // Result register, loaded at the end of the single EXEC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_zero <= 1'b0;
            r_err  <= 1'b0;
        end else if (r_state == S_EXEC) begin
            if (op_supported(r_op)) begin
                r_data <= alu_out;
                r_zero <= alu_zero;
                r_err  <= 1'b0;
            end else begin
                r_data <= '0;
                r_zero <= 1'b1;
                r_err  <= 1'b1;
            end
        end
    end

    // Unsupported codes still drive ADD so the ALU output is defined
    assign alu_ctl  = op_supported(r_op) ? r_op : ALU_ADD;
    assign alu_a    = r_a;
    assign alu_b    = r_b;
    assign rsp_data = r_data;
    assign rsp_zero = r_zero;
    assign rsp_err  = r_err;

endmodule
`default_nettype wire
